npc_pred_ctrl: RTL and testbench
================================

NPC_PRED_CTRL -- requirements
Module: npc_pred_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000; PC value driven on PC_next while rst is high.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 PC_IF  input  32  PC of the instruction currently in IF.
REQ-005 PC_pred_IF / PC_pred_en_IF  input  32/1  BTB predicted target and taken flag for PC_IF.
REQ-006 stall_IF, stall_ID, stall_EX  input  1 each  hazard-unit freezes of the PC, IF/ID and ID/EX registers.
REQ-007 jal_ID / jal_target_ID  input  1/32  JAL decoded in ID and its target.
REQ-008 PC_EX  input  32  PC of the instruction in EX.
REQ-009 br_op_EX / br_EX / br_target_EX  input  1/1/32  conditional branch in EX, its resolved outcome, and its taken target.
REQ-010 jalr_EX / jalr_target_EX  input  1/32  JALR in EX and its resolved target.
REQ-011 PC_next  output  32  next PC loaded into the PC register.
REQ-012 flush_ID / flush_EX  output  1 each  squash the IF/ID and ID/EX registers on the next edge.
REQ-013 PC_pred_en_EX / PC_pred_EX  output  1/32  prediction carried into EX; PC_pred_en_EX feeds the BTB accuracy counters.
REQ-014 redirect_ex_cnt / redirect_id_cnt  output  32 each  counts of EX corrections and ID JAL redirects.

Function
REQ-015 Prediction pipeline: two register stages (ID, EX), each holding {en, tgt}.
- IF->ID captures {PC_pred_en_IF, PC_pred_IF}.
- ID->EX captures the ID stage contents.
REQ-016 Stall and flush priority on the ID stage: flush_ID over stall_ID over load.
- Flush clears the stage to {0, 0}.
- Stall holds the stage contents.
REQ-017 Stall and flush priority on the EX stage: flush_EX over stall_EX over load.
- If stall_ID=1 and stall_EX=0, EX loads a bubble {0, 0}.
REQ-018 EX mispredict (mp_EX) is 1 when br_op_EX=1 and either of:
- br_EX differs from the EX stage en;
- br_EX=1, en=1, and the EX stage tgt differs from br_target_EX.
REQ-019 EX correct target: br_EX ? br_target_EX : PC_EX+4, using 32-bit wrapping addition.
REQ-020 ID redirect (rd_ID) is 1 when jal_ID=1 and NOT (ID stage en=1 and ID stage tgt equals jal_target_ID).
REQ-021 PC_next is combinational, evaluated in this priority order:
1. jalr_EX → jalr_target_EX.
2. mp_EX → EX correct target.
3. rd_ID → jal_target_ID.
4. stall_IF → PC_IF.
5. PC_pred_en_IF → PC_pred_IF.
6. Otherwise → PC_IF+4 (wrapping).
REQ-022 EX redirect (jalr_EX | mp_EX) sets flush_ID=1 and flush_EX=1, regardless of the stall inputs.
REQ-023 rd_ID without an EX redirect sets flush_ID=1 and flush_EX=0.
REQ-024 EX redirect masks rd_ID: neither the ID redirect nor its counter takes effect in that cycle.
REQ-025 Redirects override stall_IF: a redirect cycle always loads the redirect target.
REQ-026 redirect_ex_cnt increments by 1 on each rising edge where jalr_EX | mp_EX is 1.
REQ-027 redirect_id_cnt increments by 1 on each rising edge where rd_ID=1 and no EX redirect is active.
REQ-028 Both counters wrap from 32'hFFFF_FFFF to 0.
REQ-029 PC_pred_en_EX and PC_pred_EX are driven directly from the EX stage registers.
REQ-030 A correctly predicted branch (mp_EX=0) causes no flush and no count.

Reset
REQ-031 While rst=1:
- both stages = {0, 0};
- both counters = 0;
- PC_next = RESET_PC;
- flush_ID = 0 and flush_EX = 0.
REQ-032 Assertion of rst mid-redirect discards the redirect.
REQ-033 First edge after rst deasserts: normal operation from PC_IF.

Verification
REQ-034 PC_IF=0x100, PC_pred_en_IF=0, no stalls → PC_next=0x104, flushes 0.
REQ-035 PC_IF=0x100, PC_pred_en_IF=1, PC_pred_IF=0x80; branch reaches EX two edges later with br_EX=1, br_target_EX=0x80 → PC_pred_en_EX=1, no flush, redirect_ex_cnt unchanged.
REQ-036 Same predicted branch reaches EX with br_EX=0, PC_EX=0x100 → PC_next=0x104, flush_ID=flush_EX=1, redirect_ex_cnt +1.
REQ-037 jal_ID=1 with jal_target_ID=0x200 and mp_EX=1 in the same cycle (correct target 0x300) → PC_next=0x300, redirect_id_cnt unchanged.
REQ-038 stall_ID=1, stall_EX=0 with ID holding {1, 0x40} → EX loads a bubble (PC_pred_en_EX=0) and ID still holds {1, 0x40}.
REQ-039 Assert rst for one cycle while a redirect is active → PC_next=RESET_PC, all outputs 0, counters 0.

Source files
------------

// File: rtl/npc_pred_ctrl_if.sv
// Next-PC / branch-prediction control bundle between the fetch/decode/execute datapath and npc_pred_ctrl.
// The master side is the datapath. The slave side is the controller.
interface npc_pred_ctrl_if;
  logic [31:0] PC_IF;
  logic [31:0] PC_pred_IF;
  logic        PC_pred_en_IF;
  logic        stall_IF;
  logic        stall_ID;
  logic        stall_EX;
  logic        jal_ID;
  logic [31:0] jal_target_ID;
  logic [31:0] PC_EX;
  logic        br_op_EX;
  logic        br_EX;
  logic [31:0] br_target_EX;
  logic        jalr_EX;
  logic [31:0] jalr_target_EX;
  logic [31:0] PC_next;
  logic        flush_ID;
  logic        flush_EX;
  logic        PC_pred_en_EX;
  logic [31:0] PC_pred_EX;
  logic [31:0] redirect_ex_cnt;
  logic [31:0] redirect_id_cnt;

  modport master (
    output PC_IF, PC_pred_IF, PC_pred_en_IF, stall_IF, stall_ID, stall_EX,
           jal_ID, jal_target_ID, PC_EX, br_op_EX, br_EX, br_target_EX,
           jalr_EX, jalr_target_EX,
    input  PC_next, flush_ID, flush_EX, PC_pred_en_EX, PC_pred_EX,
           redirect_ex_cnt, redirect_id_cnt
  );

  modport slave (
    input  PC_IF, PC_pred_IF, PC_pred_en_IF, stall_IF, stall_ID, stall_EX,
           jal_ID, jal_target_ID, PC_EX, br_op_EX, br_EX, br_target_EX,
           jalr_EX, jalr_target_EX,
    output PC_next, flush_ID, flush_EX, PC_pred_en_EX, PC_pred_EX,
           redirect_ex_cnt, redirect_id_cnt
  );
endinterface

// File: rtl/npc_pred_ctrl.sv
// Next-PC selection with the BTB prediction carried through ID/EX.
// It resolves JALR, branch mispredicts and JAL redirects, generates flushes, and counts redirects.
module npc_pred_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst,
  npc_pred_ctrl_if.slave bus
);

  logic        id_en;
  logic [31:0] id_tgt;
  logic        ex_en;
  logic [31:0] ex_tgt;
  logic        mp_ex;
  logic        ex_redir;
  logic        rd_id;
  logic        id_redir;
  logic [31:0] ex_correct;
  logic [31:0] ex_cnt;
  logic [31:0] id_cnt;

  // A taken branch that was predicted taken can still mispredict on the target.
  assign mp_ex = bus.br_op_EX &
                 ((bus.br_EX != ex_en) |
                  (bus.br_EX & ex_en & (ex_tgt != bus.br_target_EX)));
  assign ex_correct = bus.br_EX ? bus.br_target_EX : bus.PC_EX + 32'd4;
  assign ex_redir   = bus.jalr_EX | mp_ex;
  assign rd_id      = bus.jal_ID & ~(id_en & (id_tgt == bus.jal_target_ID));
  assign id_redir   = rd_id & ~ex_redir;

  always_comb begin
    bus.PC_next = bus.PC_IF + 32'd4;
    if (rst)                    bus.PC_next = RESET_PC;
    else if (bus.jalr_EX)       bus.PC_next = bus.jalr_target_EX;
    else if (mp_ex)             bus.PC_next = ex_correct;
    else if (rd_id)             bus.PC_next = bus.jal_target_ID;
    else if (bus.stall_IF)      bus.PC_next = bus.PC_IF;
    else if (bus.PC_pred_en_IF) bus.PC_next = bus.PC_pred_IF;
  end

  assign bus.flush_ID        = ~rst & (ex_redir | id_redir);
  assign bus.flush_EX        = ~rst & ex_redir;
  assign bus.PC_pred_en_EX   = ex_en;
  assign bus.PC_pred_EX      = ex_tgt;
  assign bus.redirect_ex_cnt = ex_cnt;
  assign bus.redirect_id_cnt = id_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_en  <= 1'b0;
      id_tgt <= 32'd0;
    end else if (bus.flush_ID) begin
      id_en  <= 1'b0;
      id_tgt <= 32'd0;
    end else if (!bus.stall_ID) begin
      id_en  <= bus.PC_pred_en_IF;
      id_tgt <= bus.PC_pred_IF;
    end
  end

  // When ID is frozen but EX advances, a bubble enters EX so the held ID entry is not duplicated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_en  <= 1'b0;
      ex_tgt <= 32'd0;
    end else if (bus.flush_EX) begin
      ex_en  <= 1'b0;
      ex_tgt <= 32'd0;
    end else if (!bus.stall_EX) begin
      if (bus.stall_ID) begin
        ex_en  <= 1'b0;
        ex_tgt <= 32'd0;
      end else begin
        ex_en  <= id_en;
        ex_tgt <= id_tgt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_cnt <= 32'd0;
      id_cnt <= 32'd0;
    end else begin
      if (ex_redir) ex_cnt <= ex_cnt + 32'd1;
      if (id_redir) id_cnt <= id_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_npc_pred_ctrl.sv
// Directed scoreboard bench for npc_pred_ctrl: expected outputs are queued as each step is driven and compared mid-cycle.
module tb_npc_pred_ctrl;
  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic clk;
  logic rst;
  npc_pred_ctrl_if bus ();

  npc_pred_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pcn;
    logic        fid;
    logic        fex;
    logic        pen;
    logic [31:0] ptgt;
    logic [31:0] cex;
    logic [31:0] cid;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic idle();
    bus.PC_IF          = 32'd0;
    bus.PC_pred_IF     = 32'd0;
    bus.PC_pred_en_IF  = 1'b0;
    bus.stall_IF       = 1'b0;
    bus.stall_ID       = 1'b0;
    bus.stall_EX       = 1'b0;
    bus.jal_ID         = 1'b0;
    bus.jal_target_ID  = 32'd0;
    bus.PC_EX          = 32'd0;
    bus.br_op_EX       = 1'b0;
    bus.br_EX          = 1'b0;
    bus.br_target_EX   = 32'd0;
    bus.jalr_EX        = 1'b0;
    bus.jalr_target_EX = 32'd0;
  endtask

  task automatic expect_out(input logic [31:0] pcn, input logic fid, input logic fex,
                            input logic pen, input logic [31:0] ptgt,
                            input logic [31:0] cex, input logic [31:0] cid);
    exp_t e;
    e.pcn = pcn; e.fid = fid; e.fex = fex; e.pen = pen;
    e.ptgt = ptgt; e.cex = cex; e.cid = cid;
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      failures++;
      $error("FAIL %s scoreboard empty", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      assert (bus.PC_next === e.pcn) else begin
        failures++; $error("FAIL %s PC_next got=%h exp=%h", tag, bus.PC_next, e.pcn);
      end
      checks++;
      assert (bus.flush_ID === e.fid) else begin
        failures++; $error("FAIL %s flush_ID got=%b exp=%b", tag, bus.flush_ID, e.fid);
      end
      checks++;
      assert (bus.flush_EX === e.fex) else begin
        failures++; $error("FAIL %s flush_EX got=%b exp=%b", tag, bus.flush_EX, e.fex);
      end
      checks++;
      assert (bus.PC_pred_en_EX === e.pen) else begin
        failures++; $error("FAIL %s PC_pred_en_EX got=%b exp=%b", tag, bus.PC_pred_en_EX, e.pen);
      end
      checks++;
      assert (bus.PC_pred_EX === e.ptgt) else begin
        failures++; $error("FAIL %s PC_pred_EX got=%h exp=%h", tag, bus.PC_pred_EX, e.ptgt);
      end
      checks++;
      assert (bus.redirect_ex_cnt === e.cex) else begin
        failures++; $error("FAIL %s redirect_ex_cnt got=%0d exp=%0d", tag, bus.redirect_ex_cnt, e.cex);
      end
      checks++;
      assert (bus.redirect_id_cnt === e.cid) else begin
        failures++; $error("FAIL %s redirect_id_cnt got=%0d exp=%0d", tag, bus.redirect_id_cnt, e.cid);
      end
    end
  endtask

  initial begin
    // A JALR redirect is active during reset; it must be discarded.
    rst = 1'b1;
    idle();
    bus.jalr_EX = 1'b1; bus.jalr_target_EX = 32'h0000_0600;
    expect_out(RST_PC, 0, 0, 0, 32'h0, 0, 0);
    #2; check_out("reset");

    // Sequential fetch with no prediction.
    @(negedge clk); rst = 1'b0; idle();
    bus.PC_IF = 32'h100;
    expect_out(32'h104, 0, 0, 0, 32'h0, 0, 0);
    #1; check_out("seq_fetch");

    // A predicted-taken branch travels to EX and resolves correctly.
    @(negedge clk); idle();
    bus.PC_IF = 32'h100; bus.PC_pred_en_IF = 1'b1; bus.PC_pred_IF = 32'h80;
    expect_out(32'h80, 0, 0, 0, 32'h0, 0, 0);
    #1; check_out("pred_taken");

    @(negedge clk); idle();
    bus.PC_IF = 32'h80;
    expect_out(32'h84, 0, 0, 0, 32'h0, 0, 0);
    #1; check_out("pred_in_id");

    @(negedge clk); idle();
    bus.PC_IF = 32'h84; bus.PC_EX = 32'h100;
    bus.br_op_EX = 1'b1; bus.br_EX = 1'b1; bus.br_target_EX = 32'h80;
    expect_out(32'h88, 0, 0, 1, 32'h80, 0, 0);
    #1; check_out("br_correct");

    // The same prediction resolves not-taken in EX.
    @(negedge clk); idle();
    bus.PC_IF = 32'h100; bus.PC_pred_en_IF = 1'b1; bus.PC_pred_IF = 32'h80;
    expect_out(32'h80, 0, 0, 0, 32'h0, 0, 0);
    #1; check_out("pred_taken2");

    @(negedge clk); idle();
    bus.PC_IF = 32'h80;
    expect_out(32'h84, 0, 0, 0, 32'h0, 0, 0);
    #1; check_out("pred_in_id2");

    @(negedge clk); idle();
    bus.PC_IF = 32'h84; bus.PC_EX = 32'h100;
    bus.br_op_EX = 1'b1; bus.br_EX = 1'b0; bus.br_target_EX = 32'h80;
    expect_out(32'h104, 1, 1, 1, 32'h80, 0, 0);
    #1; check_out("br_mispred_nt");

    @(negedge clk); idle();
    bus.PC_IF = 32'h104;
    expect_out(32'h108, 0, 0, 0, 32'h0, 1, 0);
    #1; check_out("after_mispred");

    // An EX mispredict masks a concurrent JAL redirect in ID.
    @(negedge clk); idle();
    bus.PC_IF = 32'h108; bus.PC_EX = 32'h2fc;
    bus.br_op_EX = 1'b1; bus.br_EX = 1'b1; bus.br_target_EX = 32'h300;
    bus.jal_ID = 1'b1; bus.jal_target_ID = 32'h200;
    expect_out(32'h300, 1, 1, 0, 32'h0, 1, 0);
    #1; check_out("ex_masks_id");

    @(negedge clk); idle();
    bus.PC_IF = 32'h300;
    expect_out(32'h304, 0, 0, 0, 32'h0, 2, 0);
    #1; check_out("masked_cnt");

    // A JAL redirect alone overrides stall_IF.
    @(negedge clk); idle();
    bus.PC_IF = 32'h300; bus.stall_IF = 1'b1;
    bus.jal_ID = 1'b1; bus.jal_target_ID = 32'h200;
    expect_out(32'h200, 1, 0, 0, 32'h0, 2, 0);
    #1; check_out("jal_redirect");

    @(negedge clk); idle();
    bus.PC_IF = 32'h200;
    expect_out(32'h204, 0, 0, 0, 32'h0, 2, 1);
    #1; check_out("jal_cnt");

    // A JAL predicted correctly does not redirect. The held ID entry causes a bubble in EX.
    @(negedge clk); idle();
    bus.PC_IF = 32'h200; bus.PC_pred_en_IF = 1'b1; bus.PC_pred_IF = 32'h40;
    expect_out(32'h40, 0, 0, 0, 32'h0, 2, 1);
    #1; check_out("pred_jal");

    @(negedge clk); idle();
    bus.PC_IF = 32'h40; bus.stall_IF = 1'b1; bus.stall_ID = 1'b1;
    bus.jal_ID = 1'b1; bus.jal_target_ID = 32'h40;
    expect_out(32'h40, 0, 0, 0, 32'h0, 2, 1);
    #1; check_out("jal_hit_stall");

    @(negedge clk); idle();
    bus.PC_IF = 32'h40;
    expect_out(32'h44, 0, 0, 0, 32'h0, 2, 1);
    #1; check_out("ex_bubble");

    @(negedge clk); idle();
    bus.PC_IF = 32'h44; bus.stall_IF = 1'b1; bus.stall_ID = 1'b1; bus.stall_EX = 1'b1;
    expect_out(32'h44, 0, 0, 1, 32'h40, 2, 1);
    #1; check_out("id_held");

    // Sequential PC wraps.
    @(negedge clk); idle();
    bus.PC_IF = 32'hFFFF_FFFC;
    expect_out(32'h0, 0, 0, 1, 32'h40, 2, 1);
    #1; check_out("ex_stalled_wrap");

    // JALR flushes both stages even under stalls.
    @(negedge clk); idle();
    bus.PC_IF = 32'h0; bus.stall_IF = 1'b1; bus.stall_ID = 1'b1; bus.stall_EX = 1'b1;
    bus.jalr_EX = 1'b1; bus.jalr_target_EX = 32'h500;
    expect_out(32'h500, 1, 1, 0, 32'h0, 2, 1);
    #1; check_out("jalr");

    // Taken as predicted, but to a different target.
    @(negedge clk); idle();
    bus.PC_IF = 32'h100; bus.PC_pred_en_IF = 1'b1; bus.PC_pred_IF = 32'h80;
    expect_out(32'h80, 0, 0, 0, 32'h0, 3, 1);
    #1; check_out("pred_taken3");

    @(negedge clk); idle();
    bus.PC_IF = 32'h80;
    expect_out(32'h84, 0, 0, 0, 32'h0, 3, 1);
    #1; check_out("pred_in_id3");

    @(negedge clk); idle();
    bus.PC_IF = 32'h84; bus.PC_EX = 32'h100;
    bus.br_op_EX = 1'b1; bus.br_EX = 1'b1; bus.br_target_EX = 32'h90;
    expect_out(32'h90, 1, 1, 1, 32'h80, 3, 1);
    #1; check_out("br_wrong_tgt");

    // Reset arrives while a redirect is active.
    @(negedge clk); idle();
    rst = 1'b1;
    bus.PC_IF = 32'h90; bus.jalr_EX = 1'b1; bus.jalr_target_EX = 32'h600;
    expect_out(RST_PC, 0, 0, 0, 32'h0, 0, 0);
    #1; check_out("reset_mid_redirect");

    @(negedge clk); idle();
    rst = 1'b0;
    bus.PC_IF = 32'h10;
    expect_out(32'h14, 0, 0, 0, 32'h0, 0, 0);
    #1; check_out("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
